// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter: merges the ALU writeback stream and the load-response
// writeback stream onto the single register-file write port.
// Each source has one holding register. Grants are made from the holders,
// and the register-file outputs are registered.
// Optional feature: define WB_ARB_FAIR_EN to replace fixed mem priority with
// round-robin arbitration. Same-rd ordering by age still overrides it.

package riscv_wb_arbiter_pkg;
   typedef enum logic {
      WB_ALU = 1'b0,
      WB_MEM = 1'b1
   } wb_sel_t;
endpackage

module riscv_wb_arbiter
   import riscv_wb_arbiter_pkg::*;
#(
   parameter int WORD_LENGTH = 32,
   parameter int REG_ADDR_W  = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   alu_valid,
   input  logic [REG_ADDR_W-1:0]  alu_rd,
   input  logic [WORD_LENGTH-1:0] alu_data,
   output logic                   alu_ready,
   input  logic                   mem_valid,
   input  logic [REG_ADDR_W-1:0]  mem_rd,
   input  logic [WORD_LENGTH-1:0] mem_data,
   output logic                   mem_ready,
   output logic                   rf_we,
   output logic [REG_ADDR_W-1:0]  rf_waddr,
   output logic [WORD_LENGTH-1:0] rf_wdata,
   output wb_sel_t                wb_sel,
   output logic [1:0]             pending
);

   // holding registers, one per source
   logic                   r_alu_v;
   logic [REG_ADDR_W-1:0]  r_alu_rd;
   logic [WORD_LENGTH-1:0] r_alu_data;
   logic                   r_mem_v;
   logic [REG_ADDR_W-1:0]  r_mem_rd;
   logic [WORD_LENGTH-1:0] r_mem_data;
   // 1: the ALU entry was loaded before the mem entry
   logic                   r_alu_older;
`ifdef WB_ARB_FAIR_EN
   // 1: the last granted write came from the mem path
   logic                   r_last_mem;
`endif

   logic                   r_rf_we;
   logic [REG_ADDR_W-1:0]  r_rf_waddr;
   logic [WORD_LENGTH-1:0] r_rf_wdata;
   wb_sel_t                r_wb_sel;

   logic                   w_gnt_alu;
   logic                   w_gnt_mem;
   logic                   w_alu_acc;
   logic                   w_mem_acc;
   logic [REG_ADDR_W-1:0]  w_gnt_rd;
   logic [WORD_LENGTH-1:0] w_gnt_data;
   logic                   w_wr;
   logic                   w_alu_keep;
   logic                   w_mem_keep;

   assign alu_ready  = !r_alu_v || w_gnt_alu;
   assign mem_ready  = !r_mem_v || w_gnt_mem;
   assign w_alu_acc  = alu_valid && alu_ready;
   assign w_mem_acc  = mem_valid && mem_ready;
   assign w_gnt_rd   = w_gnt_mem ? r_mem_rd : r_alu_rd;
   assign w_gnt_data = w_gnt_mem ? r_mem_data : r_alu_data;
   assign w_wr       = (w_gnt_alu || w_gnt_mem) && (w_gnt_rd != {REG_ADDR_W{1'b0}});
   // an entry that survives this edge without being replaced
   assign w_alu_keep = r_alu_v && !w_gnt_alu;
   assign w_mem_keep = r_mem_v && !w_gnt_mem;

   assign rf_we    = r_rf_we;
   assign rf_waddr = r_rf_waddr;
   assign rf_wdata = r_rf_wdata;
   assign wb_sel   = r_wb_sel;
   assign pending  = {1'b0, r_alu_v} + {1'b0, r_mem_v};

   // grant selection: same-rd age ordering first, then priority / round-robin
   always_comb begin
      w_gnt_alu = 1'b0;
      w_gnt_mem = 1'b0;
      if (r_alu_v && r_mem_v) begin
         if ((r_alu_rd == r_mem_rd) && (r_alu_rd != {REG_ADDR_W{1'b0}})) begin
            w_gnt_alu = r_alu_older;
            w_gnt_mem = !r_alu_older;
         end else begin
`ifdef WB_ARB_FAIR_EN
            w_gnt_alu = r_last_mem;
            w_gnt_mem = !r_last_mem;
`else
            w_gnt_mem = 1'b1;
`endif
         end
      end else if (r_alu_v) begin
         w_gnt_alu = 1'b1;
      end else if (r_mem_v) begin
         w_gnt_mem = 1'b1;
      end else begin
         w_gnt_alu = 1'b0;
         w_gnt_mem = 1'b0;
      end
   end

   // ALU holder: load on accept, clear when granted and not reloaded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_v    <= 1'b0;
         r_alu_rd   <= {REG_ADDR_W{1'b0}};
         r_alu_data <= {WORD_LENGTH{1'b0}};
      end else if (w_alu_acc) begin
         r_alu_v    <= 1'b1;
         r_alu_rd   <= alu_rd;
         r_alu_data <= alu_data;
      end else if (w_gnt_alu) begin
         r_alu_v    <= 1'b0;
      end
   end

   // mem holder: load on accept, clear when granted and not reloaded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_v    <= 1'b0;
         r_mem_rd   <= {REG_ADDR_W{1'b0}};
         r_mem_data <= {WORD_LENGTH{1'b0}};
      end else if (w_mem_acc) begin
         r_mem_v    <= 1'b1;
         r_mem_rd   <= mem_rd;
         r_mem_data <= mem_data;
      end else if (w_gnt_mem) begin
         r_mem_v    <= 1'b0;
      end
   end

   // age flag: a newly loaded entry is younger than one that stays held;
   // simultaneous loads make the ALU entry the older one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_older <= 1'b0;
      end else if (w_alu_acc && w_mem_acc) begin
         r_alu_older <= 1'b1;
      end else if (w_alu_acc && w_mem_keep) begin
         r_alu_older <= 1'b0;
      end else if (w_mem_acc && w_alu_keep) begin
         r_alu_older <= 1'b1;
      end
   end

`ifdef WB_ARB_FAIR_EN
   // round-robin pointer: remembers the source of the last granted write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_mem <= 1'b0;
      end else if (w_wr) begin
         r_last_mem <= w_gnt_mem;
      end
   end
`endif

   // register-file write port; rd==0 grants are consumed silently
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rf_we    <= 1'b0;
         r_rf_waddr <= {REG_ADDR_W{1'b0}};
         r_rf_wdata <= {WORD_LENGTH{1'b0}};
         r_wb_sel   <= WB_ALU;
      end else if (w_wr) begin
         r_rf_we    <= 1'b1;
         r_rf_waddr <= w_gnt_rd;
         r_rf_wdata <= w_gnt_data;
         r_wb_sel   <= w_gnt_mem ? WB_MEM : WB_ALU;
      end else begin
         r_rf_we    <= 1'b0;
      end
   end

endmodule
